// File: rtl/cle3_pkg.sv
// Shared decode constants and types for the CLE3 SDRD capture path.
// Imported by the bit framer and the capture top level.
package cle3_pkg;

   localparam logic KEY_WIN_SSER = 1'b0;
   localparam logic KEY_WIN_BA13 = 1'b0;
   localparam logic KEY_WIN_BA12 = 1'b1;
   localparam logic KEY_WIN_BR_W = 1'b1;

   localparam logic [3:0] SYNC_NIB_DEF = 4'h8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } hold_state_t;

   function automatic logic key_win(
      input logic sser,
      input logic ba13,
      input logic ba12,
      input logic br_w
   );
      return (sser == KEY_WIN_SSER) &&
             (ba13 == KEY_WIN_BA13) &&
             (ba12 == KEY_WIN_BA12) &&
             (br_w == KEY_WIN_BR_W);
   endfunction

endpackage

// File: rtl/cle3_bit_framer.sv
// Serial-to-byte framer for SDRD: bit counter, shift register,
// resync detection and idle timeout on partial bytes.
module cle3_bit_framer
   import cle3_pkg::*;
#(
   parameter bit         MSB_FIRST    = 1'b0,
   parameter logic [3:0] SYNC_NIB     = SYNC_NIB_DEF,
   parameter int         IDLE_TIMEOUT = 1023,
   parameter int         TO_W         = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       acc_stb,
   input  logic       sser,
   input  logic       ba13,
   input  logic       ba12,
   input  logic [3:0] ba_nib,
   input  logic       br_w,
   input  logic       sdrd,
   input  logic       sdrd_oe,
   output logic [2:0] bit_cnt,
   output logic       frame_err,
   output logic       byte_done,
   output logic [7:0] byte_val
);

   localparam bit TO_EN = (IDLE_TIMEOUT > 0);
   localparam int TO_LAST_I =
      TO_EN ? IDLE_TIMEOUT - 1 : 0;
   localparam logic [TO_W-1:0] TO_LAST =
      TO_LAST_I[TO_W-1:0];
   localparam logic [TO_W-1:0] TO_MAX = '1;

   logic [7:0]      sreg;
   logic [7:0]      sreg_sh;
   logic [TO_W-1:0] to_cnt;
   logic            qual;
   logic            sync;
   logic            shift;
   logic            to_hit;
   logic            partial;

   always_comb begin
      qual    = acc_stb &
                key_win(sser, ba13, ba12, br_w);
      sync    = qual & (ba_nib == SYNC_NIB);
      shift   = qual & ~sync & sdrd_oe;
      partial = (bit_cnt != 3'd0);
      sreg_sh = MSB_FIRST ? {sreg[6:0], sdrd}
                          : {sdrd, sreg[7:1]};
      // Fires on the edge where the count would reach the limit.
      to_hit  = TO_EN && !qual && partial &&
                (to_cnt == TO_LAST);
      byte_done = shift & (bit_cnt == 3'd7);
      byte_val  = sreg_sh;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg      <= '0;
         bit_cnt   <= '0;
         to_cnt    <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= (sync & partial) | to_hit;
         if (sync || to_hit) begin
            sreg    <= '0;
            bit_cnt <= '0;
         end else if (shift) begin
            sreg    <= sreg_sh;
            bit_cnt <= bit_cnt + 3'd1;
         end
         if (qual || to_hit) begin
            to_cnt <= '0;
         end else if (partial && to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cle3_sdrd_capture.sv
// Captures SDRD key-window bits into bytes and hands them to the
// host through a one-entry valid/ready holding register.
module cle3_sdrd_capture
   import cle3_pkg::*;
#(
   parameter bit         MSB_FIRST    = 1'b0,
   parameter logic [3:0] SYNC_NIB     = SYNC_NIB_DEF,
   parameter int         IDLE_TIMEOUT = 1023,
   parameter int         TO_W         = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       acc_stb,
   input  logic       SSER,
   input  logic       BA13,
   input  logic       BA12,
   input  logic [3:0] BA_NIB,
   input  logic       BR_W,
   input  logic       sdrd,
   input  logic       sdrd_oe,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic [2:0] bit_cnt,
   output logic       overrun,
   output logic       frame_err,
   input  logic       clr_ovr
);

   hold_state_t state;
   hold_state_t state_nxt;
   logic        byte_done;
   logic [7:0]  byte_val;
   logic        load;
   logic        ovr_set;

   cle3_bit_framer #(
      .MSB_FIRST    (MSB_FIRST),
      .SYNC_NIB     (SYNC_NIB),
      .IDLE_TIMEOUT (IDLE_TIMEOUT),
      .TO_W         (TO_W)
   ) u_framer (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc_stb   (acc_stb),
      .sser      (SSER),
      .ba13      (BA13),
      .ba12      (BA12),
      .ba_nib    (BA_NIB),
      .br_w      (BR_W),
      .sdrd      (sdrd),
      .sdrd_oe   (sdrd_oe),
      .bit_cnt   (bit_cnt),
      .frame_err (frame_err),
      .byte_done (byte_done),
      .byte_val  (byte_val)
   );

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      ovr_set   = 1'b0;
      unique case (state)
         EMPTY: begin
            if (byte_done) begin
               load      = 1'b1;
               state_nxt = FULL;
            end
         end
         FULL: begin
            // Same-cycle accept frees the slot for the new byte.
            if (byte_done) begin
               load    = byte_ready;
               ovr_set = ~byte_ready;
            end else if (byte_ready) begin
               state_nxt = EMPTY;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         byte_data <= '0;
         overrun   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            byte_data <= byte_val;
         end
         if (ovr_set) begin
            overrun <= 1'b1;
         end else if (clr_ovr) begin
            overrun <= 1'b0;
         end
      end
   end

   assign byte_valid = (state == FULL);

endmodule
